// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver that assembles four little-endian bytes into a 32-bit word.
// Bit timing comes from the system clock; rx is double-flopped before any use.
module uart_word_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        busy,
  output logic        frame_error,
  output logic        timeout
);

  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW       = $clog2(TO_LIMIT + 1);

  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_CNT   = TW'(TO_LIMIT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_sync1_r;
  logic          rx_sync2_r;
  logic          rx_prev_r;
  logic [1:0]    state_r,       state_nxt_s;
  logic [CW-1:0] clk_cnt_r,     clk_cnt_nxt_s;
  logic [2:0]    bit_idx_r,     bit_idx_nxt_s;
  logic [7:0]    shift_r,       shift_nxt_s;
  logic [1:0]    byte_cnt_r,    byte_cnt_nxt_s;
  logic [23:0]   lanes_r,       lanes_nxt_s;
  logic [TW-1:0] to_cnt_r,      to_cnt_nxt_s;
  logic [31:0]   data_r,        data_nxt_s;
  logic          data_valid_r,  data_valid_nxt_s;
  logic          frame_error_r, frame_error_nxt_s;
  logic          timeout_r,     timeout_nxt_s;
  logic          busy_r,        busy_nxt_s;
  logic          fall_s;

  assign data        = data_r;
  assign data_valid  = data_valid_r;
  assign frame_error = frame_error_r;
  assign timeout     = timeout_r;
  assign busy        = busy_r;

  // Next-state logic for the bit FSM, byte lanes, word output and inter-byte timeout.
  always_comb begin
    state_nxt_s       = state_r;
    clk_cnt_nxt_s     = clk_cnt_r;
    bit_idx_nxt_s     = bit_idx_r;
    shift_nxt_s       = shift_r;
    byte_cnt_nxt_s    = byte_cnt_r;
    lanes_nxt_s       = lanes_r;
    to_cnt_nxt_s      = to_cnt_r;
    data_nxt_s        = data_r;
    data_valid_nxt_s  = 1'b0;
    frame_error_nxt_s = 1'b0;
    timeout_nxt_s     = 1'b0;
    fall_s            = rx_prev_r & ~rx_sync2_r;

    case (state_r)
      IDLE: begin
        if ((byte_cnt_r != 2'd0) && (to_cnt_r == TO_CNT)) begin
          timeout_nxt_s  = 1'b1;
          byte_cnt_nxt_s = 2'd0;
          lanes_nxt_s    = 24'd0;
          to_cnt_nxt_s   = '0;
        end else if (byte_cnt_r != 2'd0) begin
          to_cnt_nxt_s = to_cnt_r + 1'b1;
        end else begin
          to_cnt_nxt_s = '0;
        end
        // A start edge coinciding with expiry still begins byte 0 of a fresh word.
        if (fall_s) begin
          state_nxt_s   = START;
          clk_cnt_nxt_s = '0;
          to_cnt_nxt_s  = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (clk_cnt_r == HALF_CNT) begin
          if (rx_sync2_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s   = DATA;
            clk_cnt_nxt_s = '0;
            bit_idx_nxt_s = 3'd0;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_r == FULL_CNT) begin
          clk_cnt_nxt_s          = '0;
          shift_nxt_s[bit_idx_r] = rx_sync2_r;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_r == FULL_CNT) begin
          clk_cnt_nxt_s = '0;
          state_nxt_s   = IDLE;
          if (rx_sync2_r) begin
            case (byte_cnt_r)
              2'd0:    lanes_nxt_s[7:0]   = shift_r;
              2'd1:    lanes_nxt_s[15:8]  = shift_r;
              2'd2:    lanes_nxt_s[23:16] = shift_r;
              default: begin
                data_nxt_s       = {shift_r, lanes_r};
                data_valid_nxt_s = 1'b1;
                lanes_nxt_s      = 24'd0;
              end
            endcase
            byte_cnt_nxt_s = byte_cnt_r + 2'd1;
          end else begin
            frame_error_nxt_s = 1'b1;
            byte_cnt_nxt_s    = 2'd0;
            lanes_nxt_s       = 24'd0;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + 1'b1;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        clk_cnt_nxt_s = '0;
      end
    endcase

    busy_nxt_s = (state_nxt_s != IDLE) || (byte_cnt_nxt_s != 2'd0);
  end

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync1_r    <= 1'b1;
      rx_sync2_r    <= 1'b1;
      rx_prev_r     <= 1'b1;
      state_r       <= IDLE;
      clk_cnt_r     <= '0;
      bit_idx_r     <= 3'd0;
      shift_r       <= 8'd0;
      byte_cnt_r    <= 2'd0;
      lanes_r       <= 24'd0;
      to_cnt_r      <= '0;
      data_r        <= 32'd0;
      data_valid_r  <= 1'b0;
      frame_error_r <= 1'b0;
      timeout_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      rx_sync1_r    <= rx;
      rx_sync2_r    <= rx_sync1_r;
      rx_prev_r     <= rx_sync2_r;
      state_r       <= state_nxt_s;
      clk_cnt_r     <= clk_cnt_nxt_s;
      bit_idx_r     <= bit_idx_nxt_s;
      shift_r       <= shift_nxt_s;
      byte_cnt_r    <= byte_cnt_nxt_s;
      lanes_r       <= lanes_nxt_s;
      to_cnt_r      <= to_cnt_nxt_s;
      data_r        <= data_nxt_s;
      data_valid_r  <= data_valid_nxt_s;
      frame_error_r <= frame_error_nxt_s;
      timeout_r     <= timeout_nxt_s;
      busy_r        <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_word_receiver.sv
// Scoreboard bench for uart_word_receiver: stimulus pushes expected pulses,
// an independent monitor pops and compares them as the DUT raises its strobes.
module tb_uart_word_receiver;

  localparam int CPB = 16;
  localparam int TOB = 32;

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_TOUT  = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] word;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] data;
  logic        data_valid;
  logic        busy;
  logic        frame_error;
  logic        timeout;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          excl_viol = 0;
  int          stab_viol = 0;
  int          n_pulses = 0;
  int          npulse;
  int          pulses_before;
  logic [31:0] last_data = 32'h0;
  logic [1:0]  kind_act;
  exp_t        e;

  uart_word_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .data_valid(data_valid),
    .busy(busy), .frame_error(frame_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] word);
    exp_t x;
    x.kind = kind;
    x.word = word;
    exp_q.push_back(x);
  endtask

  // Monitor: compares each strobe against the head of the expectation queue.
  always @(negedge clk) begin
    if (reset) begin
      last_data = 32'h0;
    end else begin
      npulse = int'(data_valid) + int'(frame_error) + int'(timeout);
      if (npulse > 1) excl_viol++;
      if (!data_valid && data !== last_data) stab_viol++;
      if (npulse != 0) begin
        n_pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {29'd0, data_valid, frame_error, timeout}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          kind_act = data_valid ? K_VALID : (frame_error ? K_FERR : K_TOUT);
          check("pulse_kind", 32'(kind_act), 32'(e.kind));
          if (e.kind == K_VALID) check("data_word", data, e.word);
        end
      end
      if (data_valid) last_data = data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_data"}, data, 32'd0);
    check({name, "_pulses"}, {29'd0, data_valid, frame_error, timeout}, 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx = 1'b1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    idle_bits(2);

    // Single word.
    push(K_VALID, 32'h0000_0001);
    send_word(32'h0000_0001);
    drain("word1");

    // Back-to-back words with zero idle between bytes.
    push(K_VALID, 32'hDEAD_BEEF);
    push(K_VALID, 32'h0000_0002);
    send_word(32'hDEAD_BEEF);
    send_word(32'h0000_0002);
    drain("b2b");

    // Bad stop bit followed by a clean word.
    push(K_FERR, 32'h0);
    push(K_VALID, 32'h0000_0003);
    send_byte(8'h55, 1'b0);
    idle_bits(1);
    send_word(32'h0000_0003);
    drain("ferr");

    // Short low glitch while idle.
    pulses_before = n_pulses;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);
    check("glitch_no_pulse", 32'(n_pulses), 32'(pulses_before));
    check("glitch_busy", 32'(busy), 32'd0);

    // Two bytes, long gap, then a full word.
    push(K_TOUT, 32'h0);
    push(K_VALID, 32'h4433_2211);
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    idle_bits(33);
    send_word(32'h4433_2211);
    drain("tout");

    // Reset in the middle of byte 2, then a full word.
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("midreset");
    reset = 1'b0;
    idle_bits(2);
    push(K_VALID, 32'h0000_0001);
    send_word(32'h0000_0001);
    drain("after_reset");

    check("pulse_exclusive", 32'(excl_viol), 32'd0);
    check("data_stable", 32'(stab_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
